a5_stream_ctrl: RTL and testbench
=================================

Name: a5_stream_ctrl

Overview:
- Sequencer for the three external majority-clocked LFSRs (19/22/23 bit) that form the image stream cipher.
- Runs clear, secret-key load, public-frame load and warm-up, then produces 8 keystream bits per pixel byte.
- XORs each pixel with its 8 keystream bits and passes it downstream over valid/ready.
- Replaces bench-side sequencing; sits between the pixel source/sink and the shift_register_a/b/c instances.

Parameters:
- FRAME_BYTES, 65536: pixels per frame before done.
- KEY_BITS, 64: secret-key length.
- FRAME_BITS, 22: public/frame-number length.
- WARMUP_CYCLES, 100: majority-clocked cycles discarded before output.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  begin key setup (sampled in IDLE only)
- abort  in  1  synchronous return to IDLE
- secret_key  in  KEY_BITS  loaded MSB first
- public_key  in  FRAME_BITS  loaded MSB first
- so1 / so2 / so3  in  19 / 22 / 23  LFSR parallel state
- lfsr_rst  out  1  active-low clear to the LFSRs
- en  out  3  per-LFSR shift enable ([0]=a, [1]=b, [2]=c)
- si  out  3  per-LFSR serial input
- pix_valid / pix_data / pix_ready  in / in / out  1 / 8 / 1  plaintext byte stream
- out_valid / out_data / out_ready  out / out / in  1 / 8 / 1  ciphertext byte stream
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Feedback terms:
  - fa = so1[13]^so1[16]^so1[17]^so1[18]
  - fb = so2[20]^so2[21]
  - fc = so3[7]^so3[20]^so3[21]^so3[22]
- Majority: maj = (so1[8]&so2[10])|(so1[8]&so3[10])|(so2[10]&so3[10]). en[k]=1 iff that LFSR's clock bit equals maj, so at least 2 bits of en are set.
- Keystream bit: ks = so1[18]^so2[21]^so3[22], taken before the step in the same cycle.
- en, si and lfsr_rst are combinational from the registered state and so*. The LFSRs shift at the posedge where en=1.
- Reset (rst=0, async): state IDLE; en=000, si=000, lfsr_rst=1, pix_ready=0, out_valid=0, out_data=0, busy=0, done=0; all counters 0.
- States:
  - IDLE: start=1 -> CLEAR.
  - CLEAR (1 cycle): lfsr_rst=0, en=000 -> KEY.
  - KEY (KEY_BITS cycles): en=111; si = {key_bit^fc, key_bit^fb, key_bit^fa}, where key_bit = secret_key[KEY_BITS-1-cnt] -> FRAME.
  - FRAME (FRAME_BITS cycles): same as KEY with public_key -> WARM.
  - WARM (WARMUP_CYCLES cycles): en = majority; si = {fc, fb, fa} -> ACCEPT.
  - ACCEPT: pix_ready=1, en=000. A handshake latches pix_data -> BITS.
  - BITS (8 cycles): ks captured into ks_byte[bcnt] (LSB first); en = majority; si = {fc, fb, fa} -> OUT.
  - OUT: out_valid=1, out_data = pix_reg^ks_byte, held stable with en=000 until out_ready. On handshake: if byte count = FRAME_BYTES-1 -> DONE, else -> ACCEPT.
  - DONE (1 cycle): done=1 -> IDLE.
- Latency: pixel accepted at cycle T; out_valid rises at T+9. Peak throughput is 1 byte per 10 cycles.
- Key setup: pix_ready rises exactly 1+KEY_BITS+FRAME_BITS+WARMUP_CYCLES = 187 cycles after start is sampled.
- start outside IDLE is ignored.
- abort in any state -> IDLE on the next edge. Pending bytes are dropped, out_valid falls, no done pulse.
- abort and start in the same IDLE cycle: abort wins.
- Counters are $clog2(max+1) wide and compare against the parameter; the byte counter cannot wrap inside a frame.

Optional Feature:
- Macro: A5_FRAME_AUTOINC_EN.
- Defined:
  - An internal FRAME_BITS frame register is loaded from public_key on start.
  - At DONE the register increments modulo 2^FRAME_BITS and the block goes to CLEAR instead of IDLE, re-keying with the new frame number.
  - done still pulses; busy stays high; only abort returns to IDLE.
- Undefined: public_key is used directly and DONE -> IDLE.

Decomposition:
- Package a5_pkg:
  - state enum;
  - tap index constants (13/16/17/18, 20/21, 7/20/21/22);
  - clock-bit indices (8, 10, 10);
  - output indices (18, 21, 22);
  - LFSR widths 19/22/23.
- One sub-module a5_clk_logic: pure combinational; computes fa, fb, fc, maj, en_maj and ks from so1/so2/so3.

Test Plan:
- rst=0 mid-WARM -> same cycle en=000, busy=0, out_valid=0; after release, state IDLE.
- start with secret_key=64'h0123456789ABCDEF, public_key=22'h34E191:
  - lfsr_rst low exactly 1 cycle;
  - en=111 for 86 cycles;
  - first si[0] = 0^fa;
  - then 100 cycles with popcount(en)>=2;
  - pix_ready high at cycle 187.
- All-zero key and frame, FRAME_BYTES=4, pixels 8'h00, 8'hFF, 8'h5A, 8'hA5 -> LFSRs stay zero, so out_data equals the input bytes; done pulses once after the 4th out handshake.
- Same key as scenario 2, 16 random pixels -> out_data matches a reference bit-accurate model of the three LFSRs.
- out_ready=0 for 20 cycles in OUT -> out_valid=1 with out_data stable, pix_ready=0, en=000; the byte completes on release.
- abort during BITS -> IDLE next cycle, no done.
- With A5_FRAME_AUTOINC_EN and public_key=22'h3FFFFF -> after done, CLEAR re-entered and the second setup loads frame 22'h000000.

Source files
------------

// File: rtl/a5_pkg.sv
// Shared definitions for the A5-style image stream cipher sequencer:
// FSM state encoding, LFSR widths, feedback taps, clocking bits and
// keystream output bits of the three external LFSRs (a = 19, b = 22, c = 23).
package a5_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_KEY,
    S_FRAME,
    S_WARM,
    S_ACCEPT,
    S_BITS,
    S_OUT,
    S_DONE
  } state_e;

  localparam int W_A = 19;
  localparam int W_B = 22;
  localparam int W_C = 23;

  localparam int TAP_A0 = 13;
  localparam int TAP_A1 = 16;
  localparam int TAP_A2 = 17;
  localparam int TAP_A3 = 18;
  localparam int TAP_B0 = 20;
  localparam int TAP_B1 = 21;
  localparam int TAP_C0 = 7;
  localparam int TAP_C1 = 20;
  localparam int TAP_C2 = 21;
  localparam int TAP_C3 = 22;

  localparam int CLK_A = 8;
  localparam int CLK_B = 10;
  localparam int CLK_C = 10;

  localparam int OUT_A = 18;
  localparam int OUT_B = 21;
  localparam int OUT_C = 22;

endpackage

// File: rtl/a5_stream_ctrl_if.sv
// Pixel-in / ciphertext-out valid/ready stream pair. The controller
// uses the slave view; the pixel source/sink uses the master view.
interface a5_stream_ctrl_if;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (
    output pix_valid, pix_data, out_ready,
    input  pix_ready, out_valid, out_data
  );

  modport slave (
    input  pix_valid, pix_data, out_ready,
    output pix_ready, out_valid, out_data
  );
endinterface

// File: rtl/a5_clk_logic.sv
// Pure combinational helper: feedback bits, majority vote, per-LFSR
// majority enables and the keystream bit, all from the current LFSR state.
module a5_clk_logic
  import a5_pkg::*;
(
  input  logic [W_A-1:0] so1,
  input  logic [W_B-1:0] so2,
  input  logic [W_C-1:0] so3,
  output logic           fa,
  output logic           fb,
  output logic           fc,
  output logic           maj,
  output logic [2:0]     en_maj,
  output logic           ks
);
  logic unused_bits;

  // Feedback, majority and keystream terms from the present state
  always_comb begin
    fa          = so1[TAP_A0] ^ so1[TAP_A1] ^ so1[TAP_A2] ^ so1[TAP_A3];
    fb          = so2[TAP_B0] ^ so2[TAP_B1];
    fc          = so3[TAP_C0] ^ so3[TAP_C1] ^ so3[TAP_C2] ^ so3[TAP_C3];
    maj         = (so1[CLK_A] & so2[CLK_B]) | (so1[CLK_A] & so3[CLK_C]) |
                  (so2[CLK_B] & so3[CLK_C]);
    en_maj      = {so3[CLK_C] == maj, so2[CLK_B] == maj, so1[CLK_A] == maj};
    ks          = so1[OUT_A] ^ so2[OUT_B] ^ so3[OUT_C];
    unused_bits = ^{so1, so2, so3};
  end
endmodule

// File: rtl/a5_stream_ctrl.sv
// Sequencer for the three majority-clocked LFSRs: clear, key load, frame
// load, warm-up, then 8 keystream bits per pixel XORed into the output byte.
// Optional build macro A5_FRAME_AUTOINC_EN: the frame number is held
// internally, incremented after every frame, and the block re-keys itself.
// Parameters assume KEY_BITS >= 2 and FRAME_BITS >= 2.
module a5_stream_ctrl
  import a5_pkg::*;
#(
  parameter int FRAME_BYTES   = 65536,
  parameter int KEY_BITS      = 64,
  parameter int FRAME_BITS    = 22,
  parameter int WARMUP_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [KEY_BITS-1:0]   secret_key,
  input  logic [FRAME_BITS-1:0] public_key,
  input  logic [W_A-1:0]        so1,
  input  logic [W_B-1:0]        so2,
  input  logic [W_C-1:0]        so3,
  output logic                  lfsr_rst,
  output logic [2:0]            en,
  output logic [2:0]            si,
  a5_stream_ctrl_if.slave       strm,
  output logic                  busy,
  output logic                  done
);
  localparam int CNT_MAX = (KEY_BITS > FRAME_BITS) ?
                           ((KEY_BITS > WARMUP_CYCLES) ? KEY_BITS : WARMUP_CYCLES) :
                           ((FRAME_BITS > WARMUP_CYCLES) ? FRAME_BITS : WARMUP_CYCLES);
  localparam int CW  = $clog2(CNT_MAX + 1);
  localparam int BW  = $clog2(FRAME_BYTES + 1);
  localparam int KIW = $clog2(KEY_BITS);
  localparam int FIW = $clog2(FRAME_BITS);

  localparam logic [CW-1:0] KEY_LAST   = CW'(KEY_BITS - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] WARM_LAST  = CW'(WARMUP_CYCLES - 1);
  localparam logic [BW-1:0] BYTE_LAST  = BW'(FRAME_BYTES - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            bcnt_q, bcnt_d;
  logic [BW-1:0]         byte_q, byte_d;
  logic [7:0]            pix_q, pix_d;
  logic [7:0]            ks_q, ks_d;
  logic [FRAME_BITS-1:0] frame_src;
  logic [KIW-1:0]        key_idx;
  logic [FIW-1:0]        frm_idx;
  logic                  fa, fb, fc, ks, unused_maj;
  logic [2:0]            en_maj;

`ifdef A5_FRAME_AUTOINC_EN
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  assign frame_src = frame_q;
`else
  assign frame_src = public_key;
`endif

  a5_clk_logic u_clk_logic (
    .so1    (so1),
    .so2    (so2),
    .so3    (so3),
    .fa     (fa),
    .fb     (fb),
    .fc     (fc),
    .maj    (unused_maj),
    .en_maj (en_maj),
    .ks     (ks)
  );

  // Next state, counters and LFSR drive; abort overrides everything
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    byte_d   = byte_q;
    pix_d    = pix_q;
    ks_d     = ks_q;
`ifdef A5_FRAME_AUTOINC_EN
    frame_d  = frame_q;
`endif
    lfsr_rst = 1'b1;
    en       = 3'b000;
    si       = 3'b000;
    key_idx  = KIW'(KEY_BITS - 1) - KIW'(cnt_q);
    frm_idx  = FIW'(FRAME_BITS - 1) - FIW'(cnt_q);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
`ifdef A5_FRAME_AUTOINC_EN
          frame_d = public_key;
`endif
        end
      end
      S_CLEAR: begin
        lfsr_rst = 1'b0;
        cnt_d    = '0;
        bcnt_d   = '0;
        byte_d   = '0;
        state_d  = S_KEY;
      end
      S_KEY: begin
        en = 3'b111;
        si = {3{secret_key[key_idx]}} ^ {fc, fb, fa};
        if (cnt_q == KEY_LAST) begin
          cnt_d   = '0;
          state_d = S_FRAME;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FRAME: begin
        en = 3'b111;
        si = {3{frame_src[frm_idx]}} ^ {fc, fb, fa};
        if (cnt_q == FRAME_LAST) begin
          cnt_d   = '0;
          state_d = S_WARM;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WARM: begin
        en = en_maj;
        si = {fc, fb, fa};
        if (cnt_q == WARM_LAST) begin
          cnt_d   = '0;
          state_d = S_ACCEPT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACCEPT: begin
        if (strm.pix_valid) begin
          pix_d   = strm.pix_data;
          bcnt_d  = '0;
          state_d = S_BITS;
        end
      end
      S_BITS: begin
        en           = en_maj;
        si           = {fc, fb, fa};
        ks_d[bcnt_q] = ks;
        bcnt_d       = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) state_d = S_OUT;
      end
      S_OUT: begin
        if (strm.out_ready) begin
          if (byte_q == BYTE_LAST) begin
            state_d = S_DONE;
          end else begin
            byte_d  = byte_q + BW'(1);
            state_d = S_ACCEPT;
          end
        end
      end
      S_DONE: begin
`ifdef A5_FRAME_AUTOINC_EN
        frame_d = frame_q + FRAME_BITS'(1);
        state_d = S_CLEAR;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      bcnt_d  = '0;
      byte_d  = '0;
    end
  end

  // Control state: FSM and counters, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      byte_q  <= byte_d;
    end
  end

  // Datapath registers: always rewritten before use, so no reset needed
  always_ff @(posedge clk) begin
    pix_q   <= pix_d;
    ks_q    <= ks_d;
`ifdef A5_FRAME_AUTOINC_EN
    frame_q <= frame_d;
`endif
  end

  assign strm.pix_ready = (state_q == S_ACCEPT);
  assign strm.out_valid = (state_q == S_OUT);
  assign strm.out_data  = (state_q == S_OUT) ? (pix_q ^ ks_q) : 8'h00;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
endmodule

// File: tb/tb_a5_stream_ctrl.sv
// Bench for a5_stream_ctrl: drives the three LFSRs as simple shift
// registers under DUT control and compares ciphertext against an
// independent A5-style keystream model. Frames are 4 bytes long.
module tb_a5_stream_ctrl;
  localparam int FB = 4;
`ifdef A5_FRAME_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam logic [63:0] KEY   = 64'h0123456789ABCDEF;
  localparam logic [21:0] FRAME = 22'h34E191;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [63:0] secret_key;
  logic [21:0] public_key;
  logic [18:0] so1 = '0;
  logic [21:0] so2 = '0;
  logic [22:0] so3 = '0;
  logic        lfsr_rst, busy, done;
  logic [2:0]  en, si;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  logic [7:0]  pix_tab [FB];

  a5_stream_ctrl_if strm ();

  a5_stream_ctrl #(.FRAME_BYTES(FB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .secret_key (secret_key),
    .public_key (public_key),
    .so1        (so1),
    .so2        (so2),
    .so3        (so3),
    .lfsr_rst   (lfsr_rst),
    .en         (en),
    .si         (si),
    .strm       (strm),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // External LFSRs: synchronous active-low clear, shift toward the MSB
  always_ff @(posedge clk) begin
    if (!lfsr_rst) begin
      so1 <= '0;
      so2 <= '0;
      so3 <= '0;
    end else begin
      if (en[0]) so1 <= {so1[17:0], si[0]};
      if (en[1]) so2 <= {so2[20:0], si[1]};
      if (en[2]) so3 <= {so3[21:0], si[2]};
    end
  end

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference keystream generator, array based
  bit ra [19];
  bit rb [22];
  bit rc [23];

  task automatic m_step(input bit all, input bit din);
    bit fa_, fb_, fc_, m;
    fa_ = ra[13] ^ ra[16] ^ ra[17] ^ ra[18];
    fb_ = rb[20] ^ rb[21];
    fc_ = rc[7] ^ rc[20] ^ rc[21] ^ rc[22];
    m   = (int'(ra[8]) + int'(rb[10]) + int'(rc[10])) >= 2;
    if (all || ra[8] == m) begin
      for (int i = 18; i > 0; i--) ra[i] = ra[i-1];
      ra[0] = fa_ ^ din;
    end
    if (all || rb[10] == m) begin
      for (int i = 21; i > 0; i--) rb[i] = rb[i-1];
      rb[0] = fb_ ^ din;
    end
    if (all || rc[10] == m) begin
      for (int i = 22; i > 0; i--) rc[i] = rc[i-1];
      rc[0] = fc_ ^ din;
    end
  endtask

  task automatic m_init(input logic [63:0] k, input logic [21:0] f);
    logic [63:0] kk;
    logic [21:0] ff;
    kk = k;
    ff = f;
    for (int i = 0; i < 19; i++) ra[i] = 1'b0;
    for (int i = 0; i < 22; i++) rb[i] = 1'b0;
    for (int i = 0; i < 23; i++) rc[i] = 1'b0;
    for (int i = 0; i < 64; i++) begin m_step(1'b1, kk[63]); kk = kk << 1; end
    for (int i = 0; i < 22; i++) begin m_step(1'b1, ff[21]); ff = ff << 1; end
    for (int i = 0; i < 100; i++) m_step(1'b0, 1'b0);
  endtask

  task automatic m_byte(output logic [7:0] b);
    b = 8'h00;
    for (int j = 0; j < 8; j++) begin
      b = {ra[18] ^ rb[21] ^ rc[22], b[7:1]};
      m_step(1'b0, 1'b0);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] p, input int stall, output logic [7:0] got);
    int  n;
    bit  hold_ok;
    n = 0;
    while (!strm.pix_ready && n < 400) begin @(posedge clk); #1; n++; end
    chk("pix_ready_wait", 64'(n < 400), 64'd1);
    strm.pix_valid = 1'b1;
    strm.pix_data  = p;
    @(posedge clk); #1;
    strm.pix_valid = 1'b0;
    strm.pix_data  = 8'($urandom);
    n = 1;
    while (!strm.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("out_latency", 64'(n), 64'd9);
    chk("out_en_idle", 64'(en), 64'd0);
    got     = strm.out_data;
    hold_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (!(strm.out_valid && strm.out_data == got && !strm.pix_ready && en == 3'b000))
        hold_ok = 1'b0;
    end
    if (stall > 0) chk("stall_hold", 64'(hold_ok), 64'd1);
    strm.out_ready = 1'b1;
    @(posedge clk); #1;
    strm.out_ready = 1'b0;
  endtask

  task automatic run_frame(input logic [63:0] k, input logic [21:0] f, input int stall_at,
                           input bit zero_chk, input bit do_start, input bit keep);
    int         d0;
    logic [7:0] got, ksb;
    m_init(k, f);
    d0 = done_cnt;
    if (do_start) begin
      secret_key = k;
      public_key = f;
      pulse_start();
    end
    for (int i = 0; i < FB; i++) begin
      send_pixel(pix_tab[i], (i == stall_at) ? 20 : 0, got);
      m_byte(ksb);
      if (zero_chk) chk("zero_key_data", 64'(got), 64'(pix_tab[i]));
      else          chk("cipher_data", 64'(got), 64'(pix_tab[i] ^ ksb));
      if (i < FB - 1) chk("no_early_done", 64'(done), 64'd0);
    end
    chk("done_pulse", 64'(done), 64'd1);
    @(posedge clk); #1;
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    chk("busy_after_done", 64'(busy), 64'(AUTOINC));
    if (AUTOINC && !keep) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
  endtask

  task automatic setup_checks(input logic [63:0] k, input logic [21:0] f);
    int         c, low_n, all_n, maj_n, clr_en;
    logic [2:0] si_first;
    secret_key = k;
    public_key = f;
    pulse_start();
    c = 0; low_n = 0; all_n = 0; maj_n = 0; clr_en = 1; si_first = 3'b000;
    while (!strm.pix_ready && c < 400) begin
      if (!lfsr_rst) low_n++;
      if (c == 0 && en != 3'b000) clr_en = 0;
      if (c >= 1 && c <= 86 && en == 3'b111) all_n++;
      if (c >= 87 && c <= 186 && $countones(en) >= 2) maj_n++;
      if (c == 1) si_first = si;
      start = (c == 10);
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    chk("setup_latency", 64'(c), 64'd187);
    chk("lfsr_rst_low_cycles", 64'(low_n), 64'd1);
    chk("clear_en_zero", 64'(clr_en), 64'd1);
    chk("load_en_all", 64'(all_n), 64'd86);
    chk("warm_majority", 64'(maj_n), 64'd100);
    chk("first_si", 64'(si_first), 64'({3{k[63]}}));
  endtask

  initial begin
    int d0;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    secret_key = '0; public_key = '0;
    strm.pix_valid = 1'b0; strm.pix_data = 8'h00; strm.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 64'(en), 64'd0);
    chk("rst_si", 64'(si), 64'd0);
    chk("rst_lfsr_rst", 64'(lfsr_rst), 64'd1);
    chk("rst_pix_ready", 64'(strm.pix_ready), 64'd0);
    chk("rst_out_valid", 64'(strm.out_valid), 64'd0);
    chk("rst_out_data", 64'(strm.out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // abort beats start in IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", 64'(busy), 64'd0);

    // key setup timing, with a stray start during KEY
    setup_checks(KEY, FRAME);

    // abort in the middle of BITS
    strm.pix_valid = 1'b1; strm.pix_data = 8'h3C;
    @(posedge clk); #1;
    strm.pix_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bits_busy", 64'(busy), 64'd1);
    d0 = done_cnt;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_en", 64'(en), 64'd0);
    chk("abort_out_valid", 64'(strm.out_valid), 64'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_no_out", 64'(strm.out_valid), 64'd0);

    // asynchronous reset during warm-up
    pulse_start();
    repeat (120) @(posedge clk);
    #1;
    chk("warm_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("arst_en", 64'(en), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_out_valid", 64'(strm.out_valid), 64'd0);
    chk("arst_lfsr_rst", 64'(lfsr_rst), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("arst_idle", 64'(busy), 64'd0);
    chk("arst_pix_ready", 64'(strm.pix_ready), 64'd0);

    // all-zero key and frame: ciphertext equals plaintext
    pix_tab[0] = 8'h00; pix_tab[1] = 8'hFF; pix_tab[2] = 8'h5A; pix_tab[3] = 8'hA5;
    run_frame(64'h0, 22'h0, -1, 1'b1, 1'b1, 1'b0);

    // 16 random pixels over four frames with the reference key, one stall
    for (int fr = 0; fr < 4; fr++) begin
      for (int i = 0; i < FB; i++) pix_tab[i] = 8'($urandom);
      run_frame(KEY, FRAME, (fr == 1) ? 2 : -1, 1'b0, 1'b1, 1'b0);
    end

`ifdef A5_FRAME_AUTOINC_EN
    // frame number wraps 3FFFFF -> 000000 and re-keys without start
    for (int i = 0; i < FB; i++) pix_tab[i] = 8'($urandom);
    run_frame(KEY, 22'h3FFFFF, -1, 1'b0, 1'b1, 1'b1);
    chk("autoinc_clear", 64'(lfsr_rst), 64'd0);
    for (int i = 0; i < FB; i++) pix_tab[i] = 8'($urandom);
    run_frame(KEY, 22'h000000, -1, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
